shifter_pipe: RTL
=================

Name: shifter_pipe

Overview:
Parametrised, pipelined barrel shifter; successor to the fixed 8-bit shifter. Supports logical, arithmetic and rotate modes in both directions. Uses one pipeline stage per shift-amount bit, with a valid/ready handshake and full backpressure. It is the shift unit for the datapath, fed by the issue logic and drained by the writeback mux.

Parameters:
WIDTH, 8, data width in bits; power of two, 4..64.
SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  input beat valid.
in_ready  output  1  block accepts a beat this cycle.
din  input  WIDTH  operand.
dir  input  1  1 = left, 0 = right.
mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
n  input  SHAMT_W  shift amount, 0..WIDTH-1.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
dout  output  WIDTH  shifted result.

Behaviour:
- Reset (async, rst=1): all stage valid bits and all data/control pipeline registers clear to 0. out_valid=0, dout=0, in_ready=1 once out_valid=0.
- Pipeline has SHAMT_W registered stages. Stage k (k=0..SHAMT_W-1) shifts by 2^k when its latched n[k]=1, otherwise passes through. Each stage carries dir, mode and remaining n bits.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. All stages load on adv and hold otherwise. Bubbles are not collapsed.
- Transfer rules: input accepted on in_valid && in_ready; output consumed on out_valid && out_ready.
- Latency: SHAMT_W cycles from acceptance to out_valid when unstalled (3 for WIDTH=8). Throughput is 1 beat/cycle.
- Logical shift: vacated bits fill with 0.
- Arithmetic right: vacated bits fill with the sign bit, din[WIDTH-1]. Arithmetic left is identical to logical left.
- Rotate: bits shifted out re-enter at the opposite end.
- n=0: dout=din for every mode.
- Downstream stall (out_valid=1, out_ready=0): dout and out_valid stay stable; in_ready=0.
- Simultaneous output consume and input accept: both occur in the same cycle.
- rst asserted mid-operation: in-flight beats are discarded immediately; no partial result appears after rst deasserts.
- Input fields must be held only during the handshake cycle; the stage register captures them.

Optional Feature:
SHIFTER_PIPE_CARRY_EN
- With the macro: extra output port carry (1 bit), registered alongside dout. carry = the last bit shifted out of the word in logical/arithmetic mode; in rotate mode it equals the bit that wrapped last. carry=0 when n=0. Reset value 0. Each stage computes its own carry out; a stage that does not shift passes the incoming carry through.
- Without the macro: no carry port and no carry registers.

Decomposition:
- Package shifter_pkg holds:
  - the mode enum: SHIFT_LOGICAL=2'b00, SHIFT_ARITH=2'b01, SHIFT_ROTATE=2'b10;
  - direction constants: DIR_RIGHT=0, DIR_LEFT=1.
- Sub-module shifter_stage:
  - purely combinational shift by a fixed 2^K (parameter K);
  - carry out included when SHIFTER_PIPE_CARRY_EN is defined.
- shifter_pipe generates SHAMT_W instances of shifter_stage and owns the pipeline registers and handshake.

Test Plan:
- Left logical: WIDTH=8, din=8'b10101001, dir=1, mode=00, n=2 -> dout=8'b10100100 after 3 cycles; carry=0.
- Right logical: din=8'b10110101, dir=0, mode=00, n=3 -> dout=8'b00010110; carry=1.
- Arithmetic right: din=8'b10110101, dir=0, mode=01, n=3 -> dout=8'b11110110. Rotate left: din=8'b10101001, dir=1, mode=10, n=2 -> dout=8'b10100110.
- Back-to-back and stall: 5 beats on consecutive cycles, hold out_ready=0 for 4 cycles after the first result -> in_ready=0 and dout stable during the stall; all 5 results emerge in order with none lost or duplicated.
- Edge amounts: n=0 in every mode -> dout=din, carry=0. n=7 right arithmetic on din=8'h80 -> dout=8'hFF.
- Reset mid-flight: accept 2 beats, pulse rst asynchronously (between clock edges) -> out_valid=0 and dout=0 immediately; no result emerges afterwards. A new beat after reset yields the correct result at latency 3.

Source files
------------

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shift mode and direction definitions for the shifter pipeline
//
// Purpose : shared encodings used by shifter_stage and shifter_pipe.
// Ports   : none (package).
// Options : SHIFTER_PIPE_CARRY_EN is consumed by the modules, not by this package.

package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_LOGICAL = 2'b00,
        SHIFT_ARITH   = 2'b01,
        SHIFT_ROTATE  = 2'b10
    } shift_mode_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shifter_stage.sv
// rtl/shifter_stage.sv - combinational shift by a fixed 2^K positions
//
// Purpose : one barrel-shifter layer; shifts when en=1, passes through otherwise.
// Ports   : din/dout [WIDTH] data, dir (1=left), mode [2], en (shift enable),
//           cin/cout carry chain (only with SHIFTER_PIPE_CARRY_EN).
// Options : SHIFTER_PIPE_CARRY_EN adds cin/cout.

module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             en,
`ifdef SHIFTER_PIPE_CARRY_EN
    input  logic             cin,
    output logic             cout,
`endif
    output logic [WIDTH-1:0] dout
);

    localparam int S = 2 ** K;

    always_comb begin
        dout = din;
        if (en) begin
            if (dir == DIR_LEFT) begin
                // Arithmetic left is the same as logical left.
                if (mode == SHIFT_ROTATE) begin
                    dout = (din << S) | (din >> (WIDTH - S));
                end else begin
                    dout = din << S;
                end
            end else begin
                case (mode)
                    SHIFT_ARITH:  dout = $signed(din) >>> S;
                    SHIFT_ROTATE: dout = (din >> S) | (din << (WIDTH - S));
                    default:      dout = din >> S;
                endcase
            end
        end
    end

`ifdef SHIFTER_PIPE_CARRY_EN
    // The last bit to leave the word is the one nearest the vacated end;
    // rotate wraps that same bit, so the selection is mode independent.
    always_comb begin
        cout = cin;
        if (en) begin
            cout = (dir == DIR_LEFT) ? din[WIDTH-S] : din[S-1];
        end
    end
`endif

endmodule

// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined barrel shifter, one stage per shift-amount bit
//
// Purpose : logical/arithmetic/rotate shift in both directions with a
//           valid/ready handshake and full backpressure.
// Ports   : clk, rst (async, active-high)
//           in_valid/in_ready, din [WIDTH], dir (1=left), mode [2], n [SHAMT_W]
//           out_valid/out_ready, dout [WIDTH]
//           carry (only with SHIFTER_PIPE_CARRY_EN)
// Options : SHIFTER_PIPE_CARRY_EN adds the registered carry output.

module shifter_pipe
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   din,
    input  logic               dir,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] n,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   dout
`ifdef SHIFTER_PIPE_CARRY_EN
    ,
    output logic               carry
`endif
);

    logic adv;

    logic [WIDTH-1:0]   data_q  [SHAMT_W];
    logic               dir_q   [SHAMT_W];
    logic [1:0]         mode_q  [SHAMT_W];
    logic [SHAMT_W-1:0] n_q     [SHAMT_W];
    logic               valid_q [SHAMT_W];

    logic [WIDTH-1:0]   data_src  [SHAMT_W];
    logic               dir_src   [SHAMT_W];
    logic [1:0]         mode_src  [SHAMT_W];
    logic [SHAMT_W-1:0] n_src     [SHAMT_W];
    logic               valid_src [SHAMT_W];
    logic [WIDTH-1:0]   data_d    [SHAMT_W];

`ifdef SHIFTER_PIPE_CARRY_EN
    logic carry_q   [SHAMT_W];
    logic carry_src [SHAMT_W];
    logic carry_d   [SHAMT_W];
`endif

    // The whole pipe moves as one; bubbles are kept rather than collapsed.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign data_src[k]  = din;
            assign dir_src[k]   = dir;
            assign mode_src[k]  = mode;
            assign n_src[k]     = n;
            assign valid_src[k] = in_valid;
`ifdef SHIFTER_PIPE_CARRY_EN
            assign carry_src[k] = 1'b0;
`endif
        end else begin : g_next
            assign data_src[k]  = data_q[k-1];
            assign dir_src[k]   = dir_q[k-1];
            assign mode_src[k]  = mode_q[k-1];
            assign n_src[k]     = n_q[k-1];
            assign valid_src[k] = valid_q[k-1];
`ifdef SHIFTER_PIPE_CARRY_EN
            assign carry_src[k] = carry_q[k-1];
`endif
        end

        shifter_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .din  (data_src[k]),
            .dir  (dir_src[k]),
            .mode (mode_src[k]),
            .en   (n_src[k][k]),
`ifdef SHIFTER_PIPE_CARRY_EN
            .cin  (carry_src[k]),
            .cout (carry_d[k]),
`endif
            .dout (data_d[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                data_q[k]  <= '0;
                dir_q[k]   <= 1'b0;
                mode_q[k]  <= 2'b00;
                n_q[k]     <= '0;
                valid_q[k] <= 1'b0;
`ifdef SHIFTER_PIPE_CARRY_EN
                carry_q[k] <= 1'b0;
`endif
            end
        end else if (adv) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                data_q[k]  <= data_d[k];
                dir_q[k]   <= dir_src[k];
                mode_q[k]  <= mode_src[k];
                n_q[k]     <= n_src[k];
                valid_q[k] <= valid_src[k];
`ifdef SHIFTER_PIPE_CARRY_EN
                carry_q[k] <= carry_d[k];
`endif
            end
        end
    end

    assign out_valid = valid_q[SHAMT_W-1];
    assign dout      = data_q[SHAMT_W-1];
`ifdef SHIFTER_PIPE_CARRY_EN
    assign carry     = carry_q[SHAMT_W-1];
`endif

endmodule
